// File: rtl/soc_system_pio_in_capture.sv
// Avalon-MM input PIO: synchronised inputs, per-bit edge capture (W1C),
// interrupt mask and level irq; registered reads with latency 1.
module soc_system_pio_in_capture #(
    parameter int          WIDTH          = 32,
    parameter int          SYNC_STAGES    = 2,
    parameter int          EDGE_TYPE      = 0,
    parameter logic [31:0] IRQ_MASK_RESET = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [2:0] WARM_END = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_wdata;
    logic [2:0]       r_warm;
    logic             w_warm_done;
    logic             w_wr;
    logic [31:0]      w_rdata;
    logic [31:0]      r_rdata;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_sync = in_port;
        end else begin : g_sync
            logic [WIDTH-1:0] r_sync [SYNC_STAGES];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++)
                        r_sync[i] <= '0;
                end else begin
                    r_sync[0] <= in_port;
                    for (int i = 1; i < SYNC_STAGES; i++)
                        r_sync[i] <= r_sync[i-1];
                end
            end
            assign w_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_wr        = chipselect & ~write_n;
    assign w_wdata     = writedata[WIDTH-1:0];
    assign w_warm_done = (r_warm == WARM_END);
    assign w_rise      = w_sync & ~r_prev;
    assign w_fall      = ~w_sync & r_prev;
    assign w_clr       = (w_wr && address == 2'd3) ? w_wdata : '0;

    // Edges are suppressed until the sync chain and prev hold real samples.
    always_comb begin
        w_edge = '0;
        if (w_warm_done) begin
            if (EDGE_TYPE == 0)
                w_edge = w_rise;
            else if (EDGE_TYPE == 1)
                w_edge = w_fall;
            else
                w_edge = w_rise | w_fall;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            2'd0:    w_rdata[WIDTH-1:0] = w_sync;
            2'd2:    w_rdata[WIDTH-1:0] = r_mask;
            2'd3:    w_rdata[WIDTH-1:0] = r_cap;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev  <= '0;
            r_cap   <= '0;
            r_mask  <= IRQ_MASK_RESET[WIDTH-1:0];
            r_warm  <= '0;
            r_rdata <= '0;
        end else begin
            r_prev  <= w_sync;
            r_cap   <= (r_cap & ~w_clr) | w_edge;
            r_rdata <= w_rdata;
            if (w_wr && address == 2'd2)
                r_mask <= w_wdata;
            if (!w_warm_done)
                r_warm <= r_warm + 3'd1;
        end
    end

    assign readdata = r_rdata;
    assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_soc_system_pio_in_capture.sv
// Bench for soc_system_pio_in_capture: two configurations checked every
// cycle against a sample-history reference model.
module tb_soc_system_pio_in_capture;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  a0, a1;
    logic        cs0, cs1, wn0, wn1;
    logic [31:0] wd0, wd1, rd0, rd1;
    logic [31:0] ip0;
    logic [7:0]  ip1;
    logic        irq0, irq1;

    always #5 clk = ~clk;

    soc_system_pio_in_capture #(
        .WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MASK_RESET(32'h0)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(a0), .chipselect(cs0),
        .write_n(wn0), .writedata(wd0), .readdata(rd0), .in_port(ip0),
        .irq(irq0)
    );

    soc_system_pio_in_capture #(
        .WIDTH(8), .SYNC_STAGES(0), .EDGE_TYPE(2), .IRQ_MASK_RESET(32'h5A)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(a1), .chipselect(cs1),
        .write_n(wn1), .writedata(wd1), .readdata(rd1), .in_port(ip1),
        .irq(irq1)
    );

    int          S  [2] = '{2, 0};
    int          E  [2] = '{0, 2};
    logic [31:0] WM [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] MR [2] = '{32'h0, 32'h5A};

    // hist[d][k] = in_port sampled at clock edge k after reset release
    logic [31:0] hist [2][8192];
    int          n;
    logic [31:0] m_mask [2];
    logic [31:0] m_cap  [2];
    logic [31:0] m_rd   [2];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t",
                      tag, got, exp, $time);
    endtask

    function automatic logic [31:0] H(input int d, input int i);
        return (i < 1) ? 32'h0 : hist[d][i];
    endfunction

    task automatic mreset();
        n = 0;
        for (int d = 0; d < 2; d++) begin
            m_mask[d] = MR[d];
            m_cap[d]  = '0;
            m_rd[d]   = '0;
        end
    endtask

    task automatic tick();
        logic [31:0] nm [2];
        logic [31:0] nc [2];
        logic [31:0] nr [2];
        logic [31:0] sb, pb, ed, clr, wdv;
        logic [1:0]  ad;
        logic        wr;
        n++;
        hist[0][n] = ip0;
        hist[1][n] = {24'h0, ip1};
        for (int d = 0; d < 2; d++) begin
            sb = H(d, n - S[d]);
            pb = H(d, n - 1 - S[d]);
            case (E[d])
                0:       ed = sb & ~pb;
                1:       ed = ~sb & pb;
                default: ed = sb ^ pb;
            endcase
            if (n < S[d] + 2) ed = '0;
            ad  = (d == 0) ? a0 : a1;
            wr  = (d == 0) ? (cs0 & ~wn0) : (cs1 & ~wn1);
            wdv = ((d == 0) ? wd0 : wd1) & WM[d];
            case (ad)
                2'd0:    nr[d] = sb;
                2'd2:    nr[d] = m_mask[d];
                2'd3:    nr[d] = m_cap[d];
                default: nr[d] = '0;
            endcase
            nm[d] = (wr && ad == 2'd2) ? wdv : m_mask[d];
            clr   = (wr && ad == 2'd3) ? wdv : '0;
            nc[d] = (m_cap[d] & ~clr) | ed;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            m_mask[d] = nm[d];
            m_cap[d]  = nc[d];
            m_rd[d]   = nr[d];
        end
        chk("rd0", rd0, m_rd[0]);
        chk("irq0", {31'h0, irq0}, {31'h0, |(m_cap[0] & m_mask[0])});
        chk("rd1", rd1, m_rd[1]);
        chk("irq1", {31'h0, irq1}, {31'h0, |(m_cap[1] & m_mask[1])});
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic idle();
        cs0 = 1'b0; wn0 = 1'b1; wd0 = '0;
        cs1 = 1'b0; wn1 = 1'b1; wd1 = '0;
    endtask

    task automatic wr0(input logic [1:0] ad, input logic [31:0] v);
        a0 = ad; cs0 = 1'b1; wn0 = 1'b0; wd0 = v;
        tick();
        cs0 = 1'b0; wn0 = 1'b1;
    endtask

    task automatic wr1(input logic [1:0] ad, input logic [31:0] v);
        a1 = ad; cs1 = 1'b1; wn1 = 1'b0; wd1 = v;
        tick();
        cs1 = 1'b0; wn1 = 1'b1;
    endtask

    initial begin
        idle();
        a0 = 2'd3; a1 = 2'd3;
        ip0 = 32'hFFFF_FFFF; ip1 = 8'hFF;
        mreset();
        #12;
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_irq0", {31'h0, irq0}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // inputs high across reset release must not look like edges
        ticks(10);
        chk("warm_cap", rd0, 32'h0);
        chk("warm_irq", {31'h0, irq0}, 32'h0);
        a0 = 2'd0;
        tick();
        chk("warm_data", rd0, 32'hFFFF_FFFF);

        ip0 = 32'h0; ip1 = 8'h0;
        ticks(4);
        wr0(2'd2, 32'h1);
        wr0(2'd3, 32'hFFFF_FFFF);
        wr1(2'd3, 32'hFF);
        ip0 = 32'hA5; a0 = 2'd3;
        ticks(4);
        chk("a5_cap", rd0, 32'hA5);
        chk("a5_irq", {31'h0, irq0}, 32'h1);
        wr0(2'd3, 32'h1);
        tick();
        chk("w1c_cap", rd0, 32'hA4);
        chk("w1c_irq", {31'h0, irq0}, 32'h0);

        // W1C of bit 3 coinciding with a fresh rising edge on bit 3
        wr0(2'd2, 32'h8);
        ip0 = 32'h8;
        ticks(4);
        ip0 = 32'h0;
        ticks(4);
        ip0 = 32'h8;
        ticks(2);
        wr0(2'd3, 32'h8);
        tick();
        chk("race_cap", rd0 & 32'h8, 32'h8);
        chk("race_irq", {31'h0, irq0}, 32'h1);

        // any-edge, unsynchronised instance: 2-clock pulse on bit 7
        ip1 = 8'h80; a1 = 2'd3;
        tick();
        a1 = 2'd3; cs1 = 1'b1; wn1 = 1'b0; wd1 = 32'h80;
        tick();
        chk("any_rise", rd1, 32'h80);
        cs1 = 1'b0; wn1 = 1'b1; ip1 = 8'h00;
        tick();
        chk("any_clr", rd1, 32'h0);
        tick();
        chk("any_fall", rd1, 32'h80);

        wr0(2'd0, 32'hFFFF_FFFF);
        a0 = 2'd0;
        tick();
        chk("ro_data", rd0, 32'h8);
        wr0(2'd1, 32'hFFFF_FFFF);
        a0 = 2'd1;
        tick();
        chk("rsvd", rd0, 32'h0);
        wr1(2'd2, 32'hFFFF_FFFF);
        a1 = 2'd2;
        tick();
        chk("mask_w8", rd1, 32'hFF);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) ip0 = $urandom;
            if ($urandom_range(0, 2) == 0) ip1 = 8'($urandom);
            a0  = 2'($urandom_range(0, 3));
            a1  = 2'($urandom_range(0, 3));
            cs0 = ($urandom_range(0, 3) == 0);
            cs1 = ($urandom_range(0, 3) == 0);
            wn0 = 1'($urandom_range(0, 1));
            wn1 = 1'($urandom_range(0, 1));
            wd0 = $urandom;
            wd1 = $urandom;
            tick();
        end
        idle();

        // asynchronous reset with pending masked captures
        ip0 = 32'h0;
        ticks(4);
        wr0(2'd3, 32'hFFFF_FFFF);
        wr0(2'd2, 32'h5);
        ip0 = 32'h5; a0 = 2'd3;
        ticks(4);
        chk("pre_rst_cap", rd0, 32'h5);
        chk("pre_rst_irq", {31'h0, irq0}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_rd0", rd0, 32'h0);
        chk("arst_irq0", {31'h0, irq0}, 32'h0);
        chk("arst_rd1", rd1, 32'h0);
        chk("arst_irq1", {31'h0, irq1}, 32'h0);
        mreset();
        @(negedge clk);
        reset_n = 1'b1;
        a0 = 2'd2; a1 = 2'd2;
        ticks(2);
        chk("rst_mask0", rd0, 32'h0);
        chk("rst_mask1", rd1, 32'h5A);
        a0 = 2'd3;
        ticks(8);
        chk("rst_cap0", rd0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
